// File: rtl/ahb_mem_slave.sv
// AHB-Lite data-side memory responder with byte-lane writes and programmable wait states.
// Define AHB_MEM_ERR_EN to answer misaligned/out-of-range transfers with a two-cycle ERROR.
module ahb_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [AW-1:0] idx_r;
  logic [1:0]    lo_r;
  logic [1:0]    size_r;
  logic          write_r;
  logic [31:0]   hrdata_r;
  logic          hreadyout_r;
  logic          hresp_r;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off_s;
  logic [1:0]    size_s;
  logic [1:0]    lo_s;
  logic [AW-1:0] idx_s;
  logic          illegal_s;
  logic          done_s;
  logic          accept_s;
  logic          commit_s;
  logic [3:0]    wr_strb_s;
  logic [31:0]   rd_word_s;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << lo;
      2'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return merged;
  endfunction

`ifdef AHB_MEM_ERR_EN
  localparam logic [31:0] BYTES = 32'(4 * DEPTH_WORDS);
  assign illegal_s = (hsize > 3'd2) || ((hsize == 3'd1) && off_s[0]) ||
                     ((hsize == 3'd2) && (off_s[1:0] != 2'b00)) || (off_s >= BYTES);
`else
  logic unused_s;
  assign illegal_s = 1'b0;
  assign unused_s  = ^off_s[31:AW+2];
`endif

  // Address-phase decode, completion detect and read word with same-word write forwarding
  always_comb begin
    off_s  = haddr - BASE_ADDR;
    size_s = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
    case (size_s)
      2'd0:    lo_s = off_s[1:0];
      2'd1:    lo_s = {off_s[1], 1'b0};
      default: lo_s = 2'b00;
    endcase
    idx_s     = off_s[AW+1:2];
    done_s    = (state_r == S_IDLE) || (state_r == S_ERR2) ||
                ((state_r == S_DATA) && (cnt_r == 4'd0));
    accept_s  = done_s && hsel && htrans[1] && hready;
    commit_s  = (state_r == S_DATA) && (cnt_r == 4'd0) && write_r;
    wr_strb_s = lane_strb(size_r, lo_r);
    if (commit_s && (idx_s == idx_r)) begin
      rd_word_s = merge_lanes(mem[idx_s], hwdata, wr_strb_s);
    end else begin
      rd_word_s = mem[idx_s];
    end
  end

  // Transfer FSM with registered bus response and captured address phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= '0;
      lo_r        <= 2'd0;
      size_r      <= 2'd0;
      write_r     <= 1'b0;
      hrdata_r    <= 32'h0000_0000;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else if ((state_r == S_DATA) && (cnt_r != 4'd0)) begin
      cnt_r       <= cnt_r - 4'd1;
      hreadyout_r <= (cnt_r == 4'd1);
    end else if (state_r == S_ERR1) begin
      state_r     <= S_ERR2;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b1;
    end else if (accept_s && illegal_s) begin
      state_r     <= S_ERR1;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      hrdata_r    <= 32'h0000_0000;
      hreadyout_r <= 1'b0;
      hresp_r     <= 1'b1;
    end else if (accept_s) begin
      state_r     <= S_DATA;
      cnt_r       <= WS;
      idx_r       <= idx_s;
      lo_r        <= lo_s;
      size_r      <= size_s;
      write_r     <= hwrite;
      hrdata_r    <= hwrite ? 32'h0000_0000 : rd_word_s;
      hreadyout_r <= (WS == 4'd0);
      hresp_r     <= 1'b0;
    end else begin
      state_r     <= S_IDLE;
      write_r     <= 1'b0;
      hrdata_r    <= 32'h0000_0000;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end
  end

  // Byte-lane write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_s[i]) begin
          mem[idx_r][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hrdata    = hrdata_r;
  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
AHB-Lite responder (slave) memory that serves the data-side bus requests issued by the multicycle RISC-V core's AHB master. It accepts pipelined address/data phases and stores byte, halfword and word writes via byte lanes. It returns read data and inserts a programmable number of wait states. Misaligned or out-of-range transfers are answered with the standard two-cycle ERROR response.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; valid byte range 0 .. 4*DEPTH_WORDS-1 (power of two).
WAIT_STATES, 1, hreadyout-low cycles inserted per OKAY data phase (0..15).
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
hsel  input  1  slave select from decoder
haddr  input  32  byte address (address phase)
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  input  1  1=write, 0=read
hsize  input  3  0=byte, 1=half, 2=word; others illegal
hwdata  input  32  write data (data phase)
hready  input  1  bus-level ready (mux of all slaves' hreadyout)
hrdata  output  32  read data, valid when hreadyout=1 in a read data phase
hreadyout  output  1  this slave's ready
hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, active-high): state=S_IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, all captured address-phase regs=0. Memory array is not cleared.
- Acceptance: an address phase is accepted at a rising edge when hsel & htrans[1] & hready=1. The edge captures offset=haddr-BASE_ADDR, hwrite and hsize. IDLE/BUSY or hsel=0 is not accepted; the next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- Error check at acceptance: illegal if hsize>2, (hsize=1 & offset[0]), (hsize=2 & offset[1:0]!=0), or offset>=4*DEPTH_WORDS.
- States:
  S_IDLE: hreadyout=1, hresp=0. Legal accept goes to S_DATA with cnt=WAIT_STATES. Illegal accept goes to S_ERR1.
  S_DATA: hreadyout=(cnt==0), hresp=0. cnt decrements each cycle while nonzero. The cycle with cnt==0 completes the transfer. At that edge: a new legal accept reloads S_DATA; an illegal accept goes to S_ERR1; otherwise go to S_IDLE.
  S_ERR1: hreadyout=0, hresp=1. Always go to S_ERR2.
  S_ERR2: hreadyout=1, hresp=1. Accept/next-state rules are the same as the completing S_DATA cycle.
- Pipelining: with WAIT_STATES=0, back-to-back NONSEQ transfers complete one per cycle.
- Writes: committed at the edge ending the completing S_DATA cycle, using hwdata sampled on that edge. Lane strobes by hsize/offset[1:0]:
  byte: lane offset[1:0], data hwdata[8*lane+7:8*lane].
  half: lanes {offset[1],0} and {offset[1],1}.
  word: all four lanes.
  Unselected bytes are unchanged.
- Reads: hrdata = full word mem[offset[..:2]] during read data-phase cycles; 0 otherwise. The core extracts bytes/halves using fn3. A read whose data phase directly follows a write to the same word returns the new data (write committed one edge earlier).
- ERROR transfers never modify memory; hrdata=0.
- Reset mid-transfer: pending transfer is discarded, a pending write is not committed, and the block returns to S_IDLE.

Optional Feature:
AHB_MEM_ERR_EN: defined means the error check and S_ERR1/S_ERR2 are implemented as above. Undefined means no ERROR is ever generated (hresp tied 0): offset wraps modulo 4*DEPTH_WORDS, misaligned low address bits are forced to 0 for the access size, and hsize>2 is treated as word.

Test Plan:
- Reset: assert reset mid-S_DATA write of 32'hDEAD_BEEF to 0x10 -> hreadyout=1, hresp=0, hrdata=0 immediately; later read of 0x10 does not return DEAD_BEEF.
- Word write/read, WAIT_STATES=1: write 0x0000_0040=32'h1234_5678, then read -> one hreadyout-low cycle per transfer; hrdata=32'h1234_5678.
- Byte/half lanes: word 0x20=0, byte write 0x23=8'hAB, half write 0x20=16'hCDEF -> read 0x20 returns 32'hAB00_CDEF.
- Pipelined, WAIT_STATES=0: NONSEQ write 0x8=32'h5, then immediate read 0x8 -> hreadyout stays 1; read returns 32'h5 in the next data phase.
- Error (AHB_MEM_ERR_EN): word write 0x6 -> cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1; word 0x4 unchanged. Same with offset 4*DEPTH_WORDS.
- IDLE/BUSY and hsel=0: htrans=01 or hsel=0 with hwrite=1 -> no state change, hreadyout=1, hresp=0, memory untouched.
